// File: rtl/ik_pkg.sv
// Shared register offsets, DH parameter indices and run-state encoding for the
// ik_swift control/status bank.
package ik_pkg;

    localparam int unsigned THETA      = 0;
    localparam int unsigned L_OFFSET   = 1;
    localparam int unsigned L_DISTANCE = 2;
    localparam int unsigned ALPHA      = 3;
    localparam int unsigned DH_PARAMS  = 4;

    localparam int unsigned CTRL     = 0;
    localparam int unsigned STATUS   = 1;
    localparam int unsigned CYCLES   = 2;
    localparam int unsigned JTYPE    = 3;
    localparam int unsigned TGT_BASE = 4;
    localparam int unsigned DH_BASE  = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } ik_state_e;

endpackage

// File: rtl/ik_wide_reg.sv
// One DW-bit shadow register written as two 32-bit halves, plus a hi/lo
// readback slice of a caller-chosen view (the shadow itself or a result).
module ik_wide_reg #(
    parameter int unsigned DW = 36
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_hi,
    input  logic          wr_lo,
    input  logic [31:0]   wdata,
    input  logic          rd_hi,
    input  logic [DW-1:0] view,
    output logic [DW-1:0] q,
    output logic [31:0]   rdata
);
    localparam int unsigned HW = DW - 32;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            if (wr_hi) q[DW-1:32] <= wdata[HW-1:0];
            if (wr_lo) q[31:0]    <= wdata;
        end
    end

    assign rdata = rd_hi ? 32'(view[DW-1:32]) : view[31:0];

endmodule

// File: rtl/ik_csr_bank.sv
// Avalon-MM control/status bank for ik_swift: shadow staging, snapshot on
// start, result capture on completion, run FSM with abort/timeout and irq.
module ik_csr_bank
    import ik_pkg::*;
#(
    parameter int unsigned NUM_JOINTS = 6,
    parameter int unsigned NUM_TARGET = 3,
    parameter int unsigned DW         = 36,
    parameter int unsigned ADDRW      = 6,
    parameter int unsigned TIMEOUT    = 1_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         chipselect,
    input  logic                         write,
    input  logic [ADDRW-1:0]             address,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq,
    output logic                         core_rst,
    output logic                         core_en,
    output logic [NUM_JOINTS-1:0]        core_joint_type,
    output logic [NUM_TARGET*DW-1:0]     core_target,
    output logic [NUM_JOINTS*4*DW-1:0]   core_dh_in,
    input  logic [NUM_JOINTS*4*DW-1:0]   core_dh_out,
    input  logic                         core_done
);
    localparam int unsigned NDH   = NUM_JOINTS * DH_PARAMS;
    localparam bit          TO_EN = (TIMEOUT != 0);

    logic [1:0]            state;
    ik_state_e             state_dbg;
    logic                  busy;
    logic                  irq_en;
    logic                  done;
    logic                  error;
    logic [31:0]           cycles;
    logic [31:0]           cycles_inc;
    logic [NUM_JOINTS-1:0] shadow_jtype;
    logic [DW-1:0]         shadow_tgt [NUM_TARGET];
    logic [DW-1:0]         shadow_dh  [NDH];
    logic [31:0]           tgt_rd     [NUM_TARGET];
    logic [31:0]           dh_rd      [NDH];
    logic [NDH*DW-1:0]     result;
    logic [31:0]           rd_mux;

    logic [31:0] addr_w;
    logic        wr;
    logic        rd;
    logic        rd_hi;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_jtype;
    logic        start_req;
    logic        abort_req;
    logic        w1c_done;
    logic        w1c_error;
    logic        in_run;
    logic        done_hit;
    logic        abort_hit;
    logic        timeout_hit;

    assign addr_w    = 32'(address);
    assign wr        = chipselect & write;
    assign rd        = chipselect & ~write;
    assign rd_hi     = ~address[0];
    assign wr_ctrl   = wr && (addr_w == CTRL);
    assign wr_status = wr && (addr_w == STATUS);
    assign wr_jtype  = wr && (addr_w == JTYPE);
    assign start_req = wr_ctrl & writedata[0];
    assign abort_req = wr_ctrl & writedata[1];
    assign w1c_done  = wr_status & writedata[2];
    assign w1c_error = wr_status & writedata[3];

    // Debug view of the run state; also the single source of busy.
    assign state_dbg = ik_state_e'(state);
    assign busy      = (state_dbg != IDLE);

    // Priority inside RUN: completion, then abort, then timeout.
    assign cycles_inc  = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
    assign in_run      = (state == ST_RUN);
    assign done_hit    = in_run & core_done;
    assign abort_hit   = in_run & ~core_done & abort_req;
    assign timeout_hit = in_run & ~core_done & ~abort_req & TO_EN
                         & (cycles_inc == 32'(TIMEOUT));

    for (genvar t = 0; t < NUM_TARGET; t++) begin : g_tgt
        logic pair_hit;
        assign pair_hit = wr && (addr_w[31:1] == 31'((TGT_BASE >> 1) + t));
        ik_wide_reg #(.DW(DW)) u_reg (
            .clk   (clk),
            .reset (reset),
            .wr_hi (pair_hit & ~address[0]),
            .wr_lo (pair_hit & address[0]),
            .wdata (writedata),
            .rd_hi (rd_hi),
            .view  (shadow_tgt[t]),
            .q     (shadow_tgt[t]),
            .rdata (tgt_rd[t])
        );
    end

    // DH writes stage into shadows, but reads of the same address show results.
    for (genvar i = 0; i < NDH; i++) begin : g_dh
        logic pair_hit;
        assign pair_hit = wr && (addr_w[31:1] == 31'((DH_BASE >> 1) + i));
        ik_wide_reg #(.DW(DW)) u_reg (
            .clk   (clk),
            .reset (reset),
            .wr_hi (pair_hit & ~address[0]),
            .wr_lo (pair_hit & address[0]),
            .wdata (writedata),
            .rd_hi (rd_hi),
            .view  (result[i*DW +: DW]),
            .q     (shadow_dh[i]),
            .rdata (dh_rd[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_jtype <= '0;
        end else if (wr_jtype) begin
            shadow_jtype <= NUM_JOINTS'(writedata);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            cycles          <= '0;
            core_joint_type <= '0;
            core_target     <= '0;
            core_dh_in      <= '0;
            result          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state           <= ST_RUN;
                    cycles          <= '0;
                    core_joint_type <= shadow_jtype;
                    for (int t = 0; t < NUM_TARGET; t++) core_target[t*DW +: DW] <= shadow_tgt[t];
                    for (int i = 0; i < NDH; i++) core_dh_in[i*DW +: DW] <= shadow_dh[i];
                end
                ST_RUN: begin
                    cycles <= cycles_inc;
                    if (done_hit) begin
                        result <= core_dh_out;
                        state  <= ST_IDLE;
                    end else if (abort_hit || timeout_hit) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A flag being set overrides a coincident W1C and clears the other flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= writedata[2];
            if (done_hit) begin
                done  <= 1'b1;
                error <= 1'b0;
            end else if (timeout_hit) begin
                error <= 1'b1;
                done  <= 1'b0;
            end else begin
                if (w1c_done)  done  <= 1'b0;
                if (w1c_error) error <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (addr_w == CTRL) begin
            rd_mux = {29'b0, irq_en, 2'b0};
        end else if (addr_w == STATUS) begin
            rd_mux = {28'b0, error, done, busy, 1'b0};
        end else if (addr_w == CYCLES) begin
            rd_mux = cycles;
        end else if (addr_w == JTYPE) begin
            rd_mux = 32'(shadow_jtype);
        end
        for (int t = 0; t < NUM_TARGET; t++) begin
            if (addr_w[31:1] == 31'((TGT_BASE >> 1) + t)) rd_mux = tgt_rd[t];
        end
        for (int i = 0; i < NDH; i++) begin
            if (addr_w[31:1] == 31'((DH_BASE >> 1) + i)) rd_mux = dh_rd[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd) begin
            readdata <= rd_mux;
        end
    end

    assign irq      = irq_en & done;
    assign core_en  = in_run;
    assign core_rst = reset | (state == ST_LOAD);

endmodule

// File: tb/tb_ik_csr_bank.sv
// Bench for ik_csr_bank: directed scenarios plus randomized jobs, checked
// against a transaction-level model of the register map and run behaviour.
module tb_ik_csr_bank;
  localparam int NJ  = 6;
  localparam int NT  = 3;
  localparam int DW  = 36;
  localparam int AW  = 6;
  localparam int TO  = 20;
  localparam int NDH = NJ * 4;
  localparam logic [63:0] DMASK = (64'd1 << DW) - 64'd1;
  localparam int A_DH2A = 16 + 8 * 2 + 2 * 3;

  logic clk = 1'b0;
  logic reset;
  logic chipselect;
  logic write;
  logic [AW-1:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic irq;
  logic core_rst;
  logic core_en;
  logic [NJ-1:0] core_joint_type;
  logic [NT*DW-1:0] core_target;
  logic [NDH*DW-1:0] core_dh_in;
  logic [NDH*DW-1:0] core_dh_out;
  logic core_done;

  ik_csr_bank #(
    .NUM_JOINTS(NJ), .NUM_TARGET(NT), .DW(DW), .ADDRW(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
    .core_rst(core_rst), .core_en(core_en), .core_joint_type(core_joint_type),
    .core_target(core_target), .core_dh_in(core_dh_in),
    .core_dh_out(core_dh_out), .core_done(core_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // reference model state
  logic [63:0] m_sh_tgt[NT];
  logic [63:0] m_act_tgt[NT];
  logic [63:0] m_sh_dh[NDH];
  logic [63:0] m_act_dh[NDH];
  logic [63:0] m_res[NDH];
  logic [63:0] m_out[NDH];
  logic [NJ-1:0] m_sh_jt;
  logic [NJ-1:0] m_act_jt;
  logic m_irq_en;
  logic m_done;
  logic m_err;
  logic [31:0] m_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] v, input bit hi, input logic [31:0] d);
    if (hi) return ((v & 64'hFFFF_FFFF) | ({32'b0, d} << 32)) & DMASK;
    return (v & ~64'hFFFF_FFFF) | {32'b0, d};
  endfunction

  task automatic model_write(input int a, input logic [31:0] d, input bit running,
                             output bit abort_f);
    abort_f = 0;
    if (a == 0) begin
      m_irq_en = d[2];
      abort_f = d[1] & running;
    end else if (a == 1) begin
      if (d[2]) m_done = 0;
      if (d[3]) m_err = 0;
    end else if (a == 3) begin
      m_sh_jt = d[NJ-1:0];
    end else if (a >= 4 && a < 4 + 2 * NT) begin
      m_sh_tgt[(a - 4) / 2] = merge(m_sh_tgt[(a - 4) / 2], (a % 2) == 0, d);
    end else if (a >= 16 && a < 16 + 8 * NJ) begin
      m_sh_dh[(a - 16) / 2] = merge(m_sh_dh[(a - 16) / 2], (a % 2) == 0, d);
    end
  endtask

  function automatic logic [31:0] model_read(input int a, input bit busy);
    logic [63:0] v;
    if (a == 0) return {29'b0, m_irq_en, 2'b0};
    if (a == 1) return {28'b0, m_err, m_done, busy, 1'b0};
    if (a == 2) return m_cycles;
    if (a == 3) return 32'(m_sh_jt);
    if (a >= 4 && a < 4 + 2 * NT) v = m_sh_tgt[(a - 4) / 2];
    else if (a >= 16 && a < 16 + 8 * NJ) v = m_res[(a - 16) / 2];
    else return 32'd0;
    return (a % 2 == 0) ? v[63:32] : v[31:0];
  endfunction

  // driver tasks: entered and left on a falling edge
  task automatic bus_write(input int a, input logic [31:0] d);
    bit ab;
    chipselect = 1; write = 1; address = AW'(a); writedata = d;
    @(negedge clk);
    chipselect = 0; write = 0;
    model_write(a, d, 0, ab);
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    chipselect = 1; write = 0; address = AW'(a);
    @(negedge clk);
    chipselect = 0;
    d = readdata;
  endtask

  task automatic read_check(input int a, input string tag);
    logic [31:0] d;
    exp_q.push_back(model_read(a, 0));
    bus_read(a, d);
    check($sformatf("%s_a%0d", tag, a), d, exp_q.pop_front());
  endtask

  task automatic randomize_out();
    for (int i = 0; i < NDH; i++) m_out[i] = {$urandom, $urandom} & DMASK;
  endtask

  // k: cycle of core_done (0 = never); op 0 none, 1 host write, 2 host read at op_cyc
  task automatic run_job(input int k, input int op_cyc, input int op, input int op_a,
                         input logic [31:0] op_d);
    bit ab;
    bit fin;
    logic [31:0] exp_rd;
    exp_rd = 0;
    chipselect = 1; write = 1; address = '0; writedata = {29'b0, m_irq_en, 2'b01};
    @(negedge clk);
    chipselect = 0; write = 0;
    check("load_rst", core_rst, 1);
    check("load_en", core_en, 0);
    m_act_jt = m_sh_jt;
    m_act_tgt = m_sh_tgt;
    m_act_dh = m_sh_dh;
    for (int i = 0; i < NDH; i++) core_dh_out[i*DW +: DW] = m_out[i][DW-1:0];
    @(negedge clk);
    check("act_jt", core_joint_type, m_act_jt);
    for (int t = 0; t < NT; t++) check($sformatf("act_tgt%0d", t), core_target[t*DW +: DW], m_act_tgt[t]);
    for (int i = 0; i < NDH; i++) check($sformatf("act_dh%0d", i), core_dh_in[i*DW +: DW], m_act_dh[i]);
    fin = 0;
    for (int i = 1; i <= TO && !fin; i++) begin
      check("run_en", core_en, 1);
      check("run_rst", core_rst, 0);
      if (i == op_cyc && op == 1) begin
        chipselect = 1; write = 1; address = AW'(op_a); writedata = op_d;
      end
      if (i == op_cyc && op == 2) begin
        chipselect = 1; write = 0; address = AW'(op_a);
        exp_rd = (op_a == 2) ? 32'(i - 1) : model_read(op_a, 1);
      end
      core_done = (i == k);
      @(negedge clk);
      chipselect = 0; write = 0; core_done = 0;
      ab = 0;
      if (i == op_cyc && op == 1) model_write(op_a, op_d, 1, ab);
      if (i == op_cyc && op == 2) check($sformatf("busy_rd_a%0d", op_a), readdata, exp_rd);
      if (i == k) begin
        m_res = m_out; m_done = 1; m_err = 0; fin = 1;
      end else if (ab) begin
        fin = 1;
      end else if (i == TO) begin
        m_err = 1; m_done = 0; fin = 1;
      end
      if (fin) m_cycles = 32'(i);
    end
    check("end_en", core_en, 0);
    check("end_irq", irq, m_irq_en & m_done);
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] tgt_before;
    chipselect = 0; write = 0; address = '0; writedata = '0;
    core_done = 0; core_dh_out = '0; reset = 1;
    for (int t = 0; t < NT; t++) begin m_sh_tgt[t] = 0; m_act_tgt[t] = 0; end
    for (int i = 0; i < NDH; i++) begin m_sh_dh[i] = 0; m_act_dh[i] = 0; m_res[i] = 0; m_out[i] = 0; end
    m_sh_jt = 0; m_act_jt = 0; m_irq_en = 0; m_done = 0; m_err = 0; m_cycles = 0;

    repeat (3) @(negedge clk);
    check("rst_irq", irq, 0);
    check("rst_en", core_en, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_readdata", readdata, 0);
    reset = 0;
    @(negedge clk);
    check("post_rst_core_rst", core_rst, 0);
    check("post_rst_tgt", core_target, 0);
    for (int a = 0; a < 64; a++) read_check(a, "rst_rd");

    // completion with capture of input+1
    bus_write(A_DH2A, 32'hF);
    bus_write(A_DH2A + 1, 32'h0001_0000);
    for (int i = 0; i < NDH; i++) m_out[i] = (m_sh_dh[i] + 64'd1) & DMASK;
    run_job(10, 0, 0, 0, 0);
    bus_read(A_DH2A, d);     check("dh2a_hi", d, 32'hF);
    bus_read(A_DH2A + 1, d); check("dh2a_lo", d, 32'h0001_0001);
    bus_read(2, d);          check("cycles10", d, 32'd10);
    bus_read(1, d);          check("status_done", d, 32'h4);
    for (int a = 16; a < 64; a++) read_check(a, "res_rd");

    // shadow write during RUN does not disturb the active target
    tgt_before = m_act_tgt[0];
    randomize_out();
    run_job(8, 3, 1, 5, 32'h1234);
    check("tgt_hold", core_target[0 +: DW], tgt_before);
    randomize_out();
    run_job(5, 0, 0, 0, 0);
    check("tgt_new", core_target[31:0], 32'h1234);

    // interrupt enable, then W1C done
    bus_write(0, 32'h4);
    randomize_out();
    run_job(6, 0, 0, 0, 0);
    check("irq_set", irq, 1);
    bus_write(1, 32'h4);
    check("irq_clr", irq, 0);

    // timeout
    randomize_out();
    run_job(0, 0, 0, 0, 0);
    bus_read(1, d); check("status_timeout", d, 32'h8);
    bus_read(2, d); check("cycles_timeout", d, 32'd20);
    check("irq_timeout", irq, 0);
    for (int a = 16; a < 64; a++) read_check(a, "to_res");

    // abort together with core_done: completion wins
    randomize_out();
    run_job(7, 7, 1, 0, {29'b0, m_irq_en, 2'b10});
    bus_read(1, d); check("status_abort_done", d, 32'h4);
    for (int a = 16; a < 64; a++) read_check(a, "ad_res");

    // abort alone
    bus_write(1, 32'hC);
    randomize_out();
    run_job(0, 4, 1, 0, {29'b0, m_irq_en, 2'b10});
    bus_read(1, d); check("status_abort", d, 32'h0);
    for (int a = 16; a < 64; a++) read_check(a, "ab_res");

    // start while busy is ignored
    randomize_out();
    run_job(9, 3, 1, 0, {29'b0, m_irq_en, 2'b01});
    bus_read(2, d); check("cycles_busy_start", d, 32'd9);

    // status read while busy
    randomize_out();
    run_job(6, 2, 2, 1, 0);

    // randomized jobs
    for (int n = 0; n < 40; n++) begin
      int nw;
      int k;
      int op;
      nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++) bus_write($urandom_range(1, 63), $urandom);
      randomize_out();
      k = $urandom_range(0, 18);
      op = $urandom_range(0, 2);
      run_job(k, $urandom_range(1, 12), op, $urandom_range(0, 63), $urandom);
      read_check(1, "rnd_status");
      read_check(2, "rnd_cycles");
      for (int r = 0; r < 4; r++) read_check($urandom_range(0, 63), "rnd_rd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
